// File: rtl/wb_pkg.sv
// wb_pkg: shared types and constants for the register-file writeback arbiter.
package wb_pkg;
  localparam int WB_AW = 5;
  localparam int WB_DW = 32;
  localparam int unsigned WB_X0 = '0;
  typedef struct packed {
    logic [WB_AW-1:0] rd;
    logic [WB_DW-1:0] wd;
  } wb_req_t;
  typedef enum logic {WB_SRC_ALU = 1'b0, WB_SRC_LD = 1'b1} wb_src_e;
endpackage

// File: rtl/regfile_wb_arbiter_slot.sv
// wb_slot: one-entry writeback holding register with valid/ready handshake and x0 write filter.
module wb_slot
  import wb_pkg::*;
#(
  parameter int AW = 5,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  input  logic [AW-1:0] in_rd,
  input  logic [DW-1:0] in_wd,
  input  logic          drain,
  output logic          ready,
  output logic          load,
  output logic          full,
  output logic [AW-1:0] rd,
  output logic [DW-1:0] wd
);
  logic          full_q, full_d;
  logic [AW-1:0] rd_q, rd_d;
  logic [DW-1:0] wd_q, wd_d;
  always_comb begin
    ready  = !full_q || drain;
    load   = in_valid && ready && (in_rd != AW'(WB_X0));
    full_d = load || (full_q && !drain);
    rd_d   = load ? in_rd : rd_q;
    wd_d   = load ? in_wd : wd_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      full_q <= 1'b0;
      rd_q   <= '0;
      wd_q   <= '0;
    end else begin
      full_q <= full_d;
      rd_q   <= rd_d;
      wd_q   <= wd_d;
    end
  end
  assign full = full_q;
  assign rd   = rd_q;
  assign wd   = wd_q;
endmodule

// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: shares the reg_file write port between ALU and load writeback with age-ordered grant.
// Optional WB_HAZARD_EN adds AD1/AD2 read-address compare against pending writes.
module regfile_wb_arbiter
  import wb_pkg::*;
#(
  parameter int ADDRESS_WIDTH = 5,
  parameter int DATA_WIDTH    = 32,
  parameter int CNT_WIDTH     = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     alu_valid,
  output logic                     alu_ready,
  input  logic [ADDRESS_WIDTH-1:0] alu_rd,
  input  logic [DATA_WIDTH-1:0]    alu_wd,
  input  logic                     ld_valid,
  output logic                     ld_ready,
  input  logic [ADDRESS_WIDTH-1:0] ld_rd,
  input  logic [DATA_WIDTH-1:0]    ld_wd,
  output logic [ADDRESS_WIDTH-1:0] AD3,
  output logic [DATA_WIDTH-1:0]    WD3,
  output logic                     WE3,
  output logic                     busy,
`ifdef WB_HAZARD_EN
  input  logic [ADDRESS_WIDTH-1:0] AD1,
  input  logic [ADDRESS_WIDTH-1:0] AD2,
  output logic                     hazard,
`endif
  output logic [CNT_WIDTH-1:0]     conflict_cnt
);
  logic                     alu_full, ld_full, alu_load, ld_load, alu_gnt, ld_gnt, both_full;
  logic [ADDRESS_WIDTH-1:0] alu_q_rd, ld_q_rd;
  logic [DATA_WIDTH-1:0]    alu_q_wd, ld_q_wd;
  wb_src_e                  age_q, age_d;
  logic [CNT_WIDTH-1:0]     cnt_q, cnt_d;

  wb_slot #(.AW(ADDRESS_WIDTH), .DW(DATA_WIDTH)) u_alu (
    .clk(clk), .rst(rst), .in_valid(alu_valid), .in_rd(alu_rd), .in_wd(alu_wd), .drain(alu_gnt),
    .ready(alu_ready), .load(alu_load), .full(alu_full), .rd(alu_q_rd), .wd(alu_q_wd)
  );
  wb_slot #(.AW(ADDRESS_WIDTH), .DW(DATA_WIDTH)) u_ld (
    .clk(clk), .rst(rst), .in_valid(ld_valid), .in_rd(ld_rd), .in_wd(ld_wd), .drain(ld_gnt),
    .ready(ld_ready), .load(ld_load), .full(ld_full), .rd(ld_q_rd), .wd(ld_q_wd)
  );

  always_comb begin
    both_full = alu_full && ld_full;
    alu_gnt   = alu_full && (!ld_full || age_q == WB_SRC_ALU);
    ld_gnt    = ld_full && !alu_gnt;
    WE3       = alu_gnt || ld_gnt;
    AD3       = alu_gnt ? alu_q_rd : ld_gnt ? ld_q_rd : '0;
    WD3       = alu_gnt ? alu_q_wd : ld_gnt ? ld_q_wd : '0;
    busy      = alu_full || ld_full;
    age_d     = (alu_load && ld_load)               ? WB_SRC_ALU :
                (alu_load && ld_full && !ld_gnt)    ? WB_SRC_LD  :
                (ld_load && alu_full && !alu_gnt)   ? WB_SRC_ALU : age_q;
    cnt_d     = (both_full && !(&cnt_q)) ? cnt_q + 1'b1 : cnt_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      age_q <= WB_SRC_ALU;
      cnt_q <= '0;
    end else begin
      age_q <= age_d;
      cnt_q <= cnt_d;
    end
  end
  assign conflict_cnt = cnt_q;

`ifdef WB_HAZARD_EN
  always_comb begin
    hazard = ((AD1 != '0) && ((alu_full && AD1 == alu_q_rd) || (ld_full && AD1 == ld_q_rd))) ||
             ((AD2 != '0) && ((alu_full && AD2 == alu_q_rd) || (ld_full && AD2 == ld_q_rd)));
  end
`endif
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb_regfile_wb_arbiter: scoreboard bench for the writeback arbiter (small conflict counter to reach saturation).
module tb_regfile_wb_arbiter;
  localparam int AW = 5;
  localparam int DW = 32;
  localparam int CW = 4;
  logic clk = 1'b0;
  logic rst, alu_valid, ld_valid, alu_ready, ld_ready, WE3, busy;
  logic [AW-1:0] alu_rd, ld_rd, AD3;
  logic [DW-1:0] alu_wd, ld_wd, WD3;
  logic [CW-1:0] conflict_cnt;
`ifdef WB_HAZARD_EN
  logic [AW-1:0] AD1, AD2;
  logic hazard;
`endif
  logic [AW+DW-1:0] sb[$];
  logic [AW+DW-1:0] exp_w;
  int total = 0;
  int passed = 0;
  int exp_cnt = 0;

  regfile_wb_arbiter #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst(rst),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd(alu_rd), .alu_wd(alu_wd),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_rd(ld_rd), .ld_wd(ld_wd),
    .AD3(AD3), .WD3(WD3), .WE3(WE3), .busy(busy),
`ifdef WB_HAZARD_EN
    .AD1(AD1), .AD2(AD2), .hazard(hazard),
`endif
    .conflict_cnt(conflict_cnt)
  );

  always #5 clk = ~clk;

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    exp_cnt = 0;
    total++; if (WE3 !== 1'b0) $display("FAIL reset_we3: got %b want 0", WE3); else passed++;
    total++; if (AD3 !== '0) $display("FAIL reset_ad3: got %h want 0", AD3); else passed++;
    total++; if (WD3 !== '0) $display("FAIL reset_wd3: got %h want 0", WD3); else passed++;
    total++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else passed++;
    total++; if ({alu_ready, ld_ready} !== 2'b11) $display("FAIL reset_ready: got %b want 11", {alu_ready, ld_ready}); else passed++;
    total++; if (conflict_cnt !== '0) $display("FAIL reset_cnt: got %0d want 0", conflict_cnt); else passed++;
  endtask

  task automatic test_single();
    alu_valid = 1'b1; alu_rd = 5'd3; alu_wd = 32'hDEADBEEF;
    sb.push_back({5'd3, 32'hDEADBEEF});
    total++; if (alu_ready !== 1'b1) $display("FAIL single_ready: got %b want 1", alu_ready); else passed++;
    @(negedge clk);
    alu_valid = 1'b0;
    exp_w = sb.size() != 0 ? sb.pop_front() : '1;
    total++; if ({WE3, AD3, WD3} !== {1'b1, exp_w}) $display("FAIL single_write: got we=%b %h/%h want 1 %h", WE3, AD3, WD3, exp_w); else passed++;
    @(negedge clk);
    total++; if ({WE3, busy} !== 2'b00) $display("FAIL single_idle: got we/busy=%b want 00", {WE3, busy}); else passed++;
  endtask

  task automatic test_x0();
    alu_valid = 1'b1; alu_rd = 5'd0; alu_wd = 32'h1234;
    total++; if (alu_ready !== 1'b1) $display("FAIL x0_ready: got %b want 1", alu_ready); else passed++;
    @(negedge clk);
    alu_valid = 1'b0;
    total++; if ({WE3, busy} !== 2'b00) $display("FAIL x0_drop: got we/busy=%b want 00", {WE3, busy}); else passed++;
  endtask

  task automatic test_tie();
    alu_valid = 1'b1; alu_rd = 5'd5; alu_wd = 32'hA5A5_0005;
    ld_valid = 1'b1; ld_rd = 5'd6; ld_wd = 32'h5A5A_0006;
    sb.push_back({5'd5, 32'hA5A5_0005});
    sb.push_back({5'd6, 32'h5A5A_0006});
    @(negedge clk);
    alu_valid = 1'b0; ld_valid = 1'b0;
    exp_w = sb.size() != 0 ? sb.pop_front() : '1;
    total++; if ({WE3, AD3, WD3} !== {1'b1, exp_w}) $display("FAIL tie_first: got we=%b %h/%h want 1 %h", WE3, AD3, WD3, exp_w); else passed++;
    total++; if (ld_ready !== 1'b0) $display("FAIL tie_ld_ready: got %b want 0", ld_ready); else passed++;
    exp_cnt++;
    @(negedge clk);
    exp_w = sb.size() != 0 ? sb.pop_front() : '1;
    total++; if ({WE3, AD3, WD3} !== {1'b1, exp_w}) $display("FAIL tie_second: got we=%b %h/%h want 1 %h", WE3, AD3, WD3, exp_w); else passed++;
    total++; if (conflict_cnt !== CW'(exp_cnt)) $display("FAIL tie_cnt: got %0d want %0d", conflict_cnt, exp_cnt); else passed++;
    @(negedge clk);
    total++; if ({WE3, busy} !== 2'b00) $display("FAIL tie_idle: got we/busy=%b want 00", {WE3, busy}); else passed++;
  endtask

  task automatic test_age_refill();
    alu_valid = 1'b1; alu_rd = 5'd1; alu_wd = 32'h11;
    ld_valid = 1'b1; ld_rd = 5'd2; ld_wd = 32'h22;
    sb.push_back({5'd1, 32'h11});
    sb.push_back({5'd2, 32'h22});
    @(negedge clk);
    ld_valid = 1'b0;
    exp_w = sb.size() != 0 ? sb.pop_front() : '1;
    total++; if ({WE3, AD3, WD3} !== {1'b1, exp_w}) $display("FAIL age_w1: got we=%b %h/%h want 1 %h", WE3, AD3, WD3, exp_w); else passed++;
    total++; if (alu_ready !== 1'b1) $display("FAIL age_refill_ready: got %b want 1", alu_ready); else passed++;
    alu_rd = 5'd3; alu_wd = 32'h33;
    sb.push_back({5'd3, 32'h33});
    exp_cnt++;
    @(negedge clk);
    total++; if (alu_ready !== 1'b0) $display("FAIL age_alu_blocked: got %b want 0", alu_ready); else passed++;
    alu_valid = 1'b0;
    exp_w = sb.size() != 0 ? sb.pop_front() : '1;
    total++; if ({WE3, AD3, WD3} !== {1'b1, exp_w}) $display("FAIL age_w2: got we=%b %h/%h want 1 %h", WE3, AD3, WD3, exp_w); else passed++;
    exp_cnt++;
    @(negedge clk);
    exp_w = sb.size() != 0 ? sb.pop_front() : '1;
    total++; if ({WE3, AD3, WD3} !== {1'b1, exp_w}) $display("FAIL age_w3: got we=%b %h/%h want 1 %h", WE3, AD3, WD3, exp_w); else passed++;
    total++; if (conflict_cnt !== CW'(exp_cnt)) $display("FAIL age_cnt: got %0d want %0d", conflict_cnt, exp_cnt); else passed++;
    @(negedge clk);
    total++; if ({WE3, busy, sb.size() == 0} !== 3'b001) $display("FAIL age_idle: got we/busy/sb_empty=%b want 001", {WE3, busy, sb.size() == 0}); else passed++;
  endtask

  task automatic test_saturate();
    int base;
    base = exp_cnt;
    alu_valid = 1'b1; alu_rd = 5'd8; alu_wd = 32'h88;
    ld_valid = 1'b1; ld_rd = 5'd9; ld_wd = 32'h99;
    for (int i = 0; i < 21; i++) begin
      @(negedge clk);
      if (i == 19) begin alu_valid = 1'b0; ld_valid = 1'b0; end
      exp_cnt = (base + i > 15) ? 15 : base + i;
      total++; if ({WE3, AD3} !== {1'b1, (i % 2 == 1) ? 5'd9 : 5'd8}) $display("FAIL sat_alternate_%0d: got we=%b ad3=%0d", i, WE3, AD3); else passed++;
      total++; if (conflict_cnt !== CW'(exp_cnt)) $display("FAIL sat_cnt_%0d: got %0d want %0d", i, conflict_cnt, exp_cnt); else passed++;
    end
    @(negedge clk);
    total++; if ({WE3, busy} !== 2'b00) $display("FAIL sat_idle: got we/busy=%b want 00", {WE3, busy}); else passed++;
  endtask

  task automatic test_reset_mid();
    alu_valid = 1'b1; alu_rd = 5'd10; alu_wd = 32'hAA;
    ld_valid = 1'b1; ld_rd = 5'd11; ld_wd = 32'hBB;
    sb.push_back({5'd10, 32'hAA});
    @(negedge clk);
    alu_valid = 1'b0; ld_valid = 1'b0;
    exp_w = sb.size() != 0 ? sb.pop_front() : '1;
    total++; if ({WE3, AD3, WD3} !== {1'b1, exp_w}) $display("FAIL rstmid_w: got we=%b %h/%h want 1 %h", WE3, AD3, WD3, exp_w); else passed++;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    total++; if ({WE3, busy, alu_ready, ld_ready} !== 4'b0011) $display("FAIL rstmid_state: got we/busy/ready=%b want 0011", {WE3, busy, alu_ready, ld_ready}); else passed++;
    total++; if (conflict_cnt !== '0) $display("FAIL rstmid_cnt: got %0d want 0", conflict_cnt); else passed++;
    @(negedge clk);
    total++; if ({WE3, busy} !== 2'b00) $display("FAIL rstmid_discard: got we/busy=%b want 00", {WE3, busy}); else passed++;
  endtask

`ifdef WB_HAZARD_EN
  task automatic test_hazard();
    alu_valid = 1'b1; alu_rd = 5'd7; alu_wd = 32'h77;
    sb.push_back({5'd7, 32'h77});
    @(negedge clk);
    alu_valid = 1'b0;
    AD1 = 5'd7; AD2 = 5'd0; #1;
    total++; if (hazard !== 1'b1) $display("FAIL haz_ad1: got %b want 1", hazard); else passed++;
    AD1 = 5'd0; #1;
    total++; if (hazard !== 1'b0) $display("FAIL haz_zero: got %b want 0", hazard); else passed++;
    AD2 = 5'd7; #1;
    total++; if (hazard !== 1'b1) $display("FAIL haz_ad2: got %b want 1", hazard); else passed++;
    exp_w = sb.size() != 0 ? sb.pop_front() : '1;
    total++; if ({WE3, AD3, WD3} !== {1'b1, exp_w}) $display("FAIL haz_w: got we=%b %h/%h want 1 %h", WE3, AD3, WD3, exp_w); else passed++;
    @(negedge clk);
    AD1 = 5'd7; #1;
    total++; if (hazard !== 1'b0) $display("FAIL haz_drained: got %b want 0", hazard); else passed++;
    AD1 = 5'd0; AD2 = 5'd0;
  endtask
`endif

  initial begin
    rst = 1'b1;
    alu_valid = 1'b0; ld_valid = 1'b0;
    alu_rd = '0; ld_rd = '0; alu_wd = '0; ld_wd = '0;
`ifdef WB_HAZARD_EN
    AD1 = '0; AD2 = '0;
`endif
    test_reset();
    test_single();
    test_x0();
    test_tie();
    test_age_refill();
    test_saturate();
    test_reset_mid();
`ifdef WB_HAZARD_EN
    test_hazard();
`endif
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
